// File: rtl/sa_sched_pkg.sv
// Shared types and defaults for the systolic-array tile scheduler.
package sa_sched_pkg;
  localparam int TILE            = 32;
  localparam int DIM_W_DEF       = 6;
  localparam int ADDR_W_DEF      = 12;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WB, DONE} state_t;
endpackage

// File: rtl/sa_tile_counter.sv
// Nested m/n/k tile counter (k innermost) with registered A/B/C tile indices.
module sa_tile_counter import sa_sched_pkg::*; #(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DIM_W-1:0]  m_tiles,
  input  logic [DIM_W-1:0]  k_tiles,
  input  logic [DIM_W-1:0]  n_tiles,
  input  logic              inc_k,
  input  logic              inc_tile,
  output logic              k_first,
  output logic              k_last,
  output logic              tile_last,
  output logic [ADDR_W-1:0] a_idx,
  output logic [ADDR_W-1:0] b_idx,
  output logic [ADDR_W-1:0] c_idx
);
  logic [DIM_W-1:0]  m_cfg, k_cfg, n_cfg;
  logic [DIM_W-1:0]  m, n, k;
  logic [DIM_W-1:0]  m_nx, n_nx, k_nx;
  logic [ADDR_W-1:0] a_nx, b_nx, c_nx;
  logic              m_last, n_last;

  assign k_first   = (k == '0);
  assign k_last    = (k == k_cfg - DIM_W'(1));
  assign n_last    = (n == n_cfg - DIM_W'(1));
  assign m_last    = (m == m_cfg - DIM_W'(1));
  assign tile_last = m_last && n_last;

  always_comb begin
    m_nx = m;
    n_nx = n;
    k_nx = k;
    if (clr) begin
      m_nx = '0;
      n_nx = '0;
      k_nx = '0;
    end else if (inc_k) begin
      k_nx = k + DIM_W'(1);
    end else if (inc_tile) begin
      k_nx = '0;
      if (n_last) begin
        n_nx = '0;
        if (!m_last) m_nx = m + DIM_W'(1);
      end else begin
        n_nx = n + DIM_W'(1);
      end
    end
  end

  // Indices follow the next counter values so they land with the request pulse.
  always_comb begin
    a_nx = ADDR_W'(m_nx) * ADDR_W'(k_cfg) + ADDR_W'(k_nx);
    b_nx = ADDR_W'(k_nx) * ADDR_W'(n_cfg) + ADDR_W'(n_nx);
    c_nx = ADDR_W'(m_nx) * ADDR_W'(n_cfg) + ADDR_W'(n_nx);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      m_cfg <= m_tiles;
      k_cfg <= k_tiles;
      n_cfg <= n_tiles;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m     <= '0;
      n     <= '0;
      k     <= '0;
      a_idx <= '0;
      b_idx <= '0;
      c_idx <= '0;
    end else begin
      m     <= m_nx;
      n     <= n_nx;
      k     <= k_nx;
      a_idx <= a_nx;
      b_idx <= b_nx;
      c_idx <= c_nx;
    end
  end
endmodule

// File: rtl/sa_tile_scheduler.sv
// Tiled GEMM sequencer: drives operand load, array valid/accumulate and C-tile
// writeback in m/n/k loop order.
module sa_tile_scheduler import sa_sched_pkg::*; #(
  parameter int DIM_W       = DIM_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_m_tiles,
  input  logic [DIM_W-1:0]  i_k_tiles,
  input  logic [DIM_W-1:0]  i_n_tiles,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_load_start,
  output logic [ADDR_W-1:0] o_a_tile_idx,
  output logic [ADDR_W-1:0] o_b_tile_idx,
  input  logic              i_load_done,
  output logic              o_sa_valid,
  input  logic              i_sa_valid_result,
  output logic              o_acc_en,
  output logic              o_acc_first,
  output logic              o_wb_start,
  output logic [ADDR_W-1:0] o_c_tile_idx,
  input  logic              i_wb_done
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          start_ok, dim_zero, inc_k, inc_tile;
  logic          k_first, k_last, tile_last;

  // DONE already has busy low, so a start landing there is taken too.
  assign start_ok = i_start && (state == IDLE || state == DONE);
  assign dim_zero = (i_m_tiles == '0) || (i_k_tiles == '0) || (i_n_tiles == '0);
  assign inc_k    = (state == COMPUTE) && i_sa_valid_result && !k_last;
  assign inc_tile = (state == WB) && i_wb_done;

  assign o_acc_en    = (state == COMPUTE) && i_sa_valid_result;
  assign o_acc_first = o_acc_en && k_first;

  sa_tile_counter #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_cnt (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (start_ok),
    .m_tiles   (i_m_tiles),
    .k_tiles   (i_k_tiles),
    .n_tiles   (i_n_tiles),
    .inc_k     (inc_k),
    .inc_tile  (inc_tile),
    .k_first   (k_first),
    .k_last    (k_last),
    .tile_last (tile_last),
    .a_idx     (o_a_tile_idx),
    .b_idx     (o_b_tile_idx),
    .c_idx     (o_c_tile_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      tcnt         <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_load_start <= 1'b0;
      o_sa_valid   <= 1'b0;
      o_wb_start   <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_load_start <= 1'b0;
      o_sa_valid   <= 1'b0;
      o_wb_start   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start_ok) begin
            o_err <= 1'b0;
            if (dim_zero) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_err  <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state        <= LOAD;
              o_load_start <= 1'b1;
              o_busy       <= 1'b1;
            end
          end
        end
        LOAD: begin
          // A done coinciding with the request pulse belongs to no request.
          if (!o_load_start && i_load_done) begin
            state      <= COMPUTE;
            o_sa_valid <= 1'b1;
            tcnt       <= '0;
          end
        end
        COMPUTE: begin
          if (i_sa_valid_result) begin
            if (!k_last) begin
              state        <= LOAD;
              o_load_start <= 1'b1;
            end else begin
              state      <= WB;
              o_wb_start <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WB: begin
          if (i_wb_done) begin
            if (tile_last) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state        <= LOAD;
              o_load_start <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
